mem_bus_arbiter: RTL and testbench
==================================

# mem_bus_arbiter

Two-master, one-slave arbiter that sits directly downstream of the TTA core's instruction and data buses and merges them onto a single memory/peripheral bus. It uses round-robin grant and holds each grant until the slave completes the transfer. A watchdog terminates transfers the slave never acknowledges, so a dead address cannot hang the core. All bus ports are flat signals using the core's valid/ready convention.

## Interface
- TIMEOUT_CYCLES, 16, maximum slave-valid cycles before a forced completion; 0 disables the watchdog
- TIMEOUT_DATA, 32'hDEAD_BEEF, read data returned on a timed-out transfer
- clk_i  in  1  clock; all logic on the rising edge
- rst_i  in  1  reset; synchronous, active-high
- i_addr_i, i_valid_i  in  32, 1  instruction master request (read-only)
- i_ready_o  out  1  instruction transfer complete
- i_data_read_o  out  32  instruction read data
- d_addr_i, d_valid_i  in  32, 1  data master request
- d_data_write_i, d_wstrb_i  in  32, 4  data write data and byte strobes; wstrb 0 = read
- d_ready_o  out  1  data transfer complete
- d_data_read_o  out  32  data read data
- m_addr_o, m_valid_o  out  32, 1  slave request
- m_data_write_o, m_wstrb_o  out  32, 4  slave write data and strobes
- m_ready_i, m_data_read_i  in  1, 32  slave completion and read data
- bus_err_o  out  1  one-cycle pulse on a watchdog timeout

## Operation
- States: IDLE, GRANT_I, GRANT_D. There is also a `last` register (I/D) recording the most recently granted master.
- IDLE: only i_valid_i is high → GRANT_I. Only d_valid_i is high → GRANT_D. Both are high → grant the master opposite `last`. Neither is high → stay in IDLE.
- On entering a grant state, `last` updates and the watchdog counter clears to 0.
- GRANT_x drives the slave:
  - m_valid_o = x_valid_i and not timeout.
  - m_addr_o comes from the granted master.
  - GRANT_D forwards write data and strobes.
  - GRANT_I drives m_data_write_o = 0 and m_wstrb_o = 0.
- Completion: x_ready_o = m_ready_i and m_valid_o, combinational. x_data_read_o = m_data_read_i in that cycle. The state returns to IDLE at the next edge.
- The non-granted master's ready is 0. Its data_read output is 0 when not completing.
- Watchdog:
  - In a grant state with m_ready_i low, the counter increments each cycle.
  - When counter == TIMEOUT_CYCLES (and TIMEOUT_CYCLES ≠ 0), that cycle is a timeout cycle:
    - m_valid_o = 0.
    - x_ready_o = 1, with x_data_read_o = TIMEOUT_DATA.
    - bus_err_o = 1.
    - The state returns to IDLE next.
  - Counter width is $clog2(TIMEOUT_CYCLES+1), minimum 1.
- Abort: if the granted master drops valid before completion, m_valid_o falls in the same cycle, no ready is returned, and the state returns to IDLE next edge.
- A master holds addr, write data and strobes stable while valid is high. The arbiter does not register them.

## Timing
- Reset:
  - State = IDLE, `last` = I (so data wins the first tie), counter = 0.
  - All outputs are 0, including m_valid_o, both readies and bus_err_o.
  - A reset during a grant drops m_valid_o at the same edge. No ready is issued for the aborted transfer.
- Latency:
  - Request sampled in IDLE at cycle 0 → m_valid_o is high in cycle 1.
  - A slave ready in cycle k → master ready in cycle k.
  - Minimum request-to-ready is 2 cycles.
- Every completion is followed by one mandatory IDLE cycle with m_valid_o = 0 before the next grant.
- A master asserting valid during another's grant waits. With both continuously requesting, grants strictly alternate.
- No combinational path from any *_valid_i to m_valid_o while in IDLE.
- Timeout: m_valid_o stays high for exactly TIMEOUT_CYCLES cycles, then the timeout cycle follows.
- m_ready_i arriving in the timeout cycle is ignored.

## Test plan
- Single instruction read: i_valid_i=1, addr 0x100, slave ready in its first valid cycle with data 0x1234_5678 → m_valid_o in cycle 1, i_ready_o=1 with 0x1234_5678 in cycle 1, m_wstrb_o=0, IDLE in cycle 2.
- Tie after reset: both valid in the same cycle, slave with zero wait → the data grant is served first (write 0xCAFE_F00D, wstrb 4'hF seen on the m_* outputs), then one IDLE cycle, then the instruction grant.
- Sustained contention: both valid for 8 transfers → grant order is D,I,D,I,…, and each master receives exactly 4 readies.
- Timeout: TIMEOUT_CYCLES=4, d_valid_i=1, m_ready_i held 0 → m_valid_o high cycles 1–4, cycle 5 has d_ready_o=1 with 0xDEAD_BEEF and bus_err_o=1, IDLE at cycle 6.
- Wait states: the slave asserts ready on its 3rd valid cycle → the master's ready comes in cycle 3, the counter never reaches 4, and bus_err_o stays 0.
- Reset mid-transfer: rst_i pulsed during GRANT_D with 2 wait states elapsed → at the next edge all outputs are 0 and the state is IDLE. The next tie grants data first.

Source files
------------

// File: rtl/mem_bus_arbiter_if.sv
// Bus bundle between the instruction/data masters, the arbiter and the memory slave.
// Purpose: carries the flat core-side request/response signals and the merged slave bus.
// Modports: slave = the arbiter's view (it serves both masters and drives the slave bus);
//           master = the surrounding environment (core masters plus memory slave).
interface mem_bus_arbiter_if;
    // instruction master (read-only)
    logic [31:0] i_addr_i;
    logic        i_valid_i;
    logic        i_ready_o;
    logic [31:0] i_data_read_o;

    // data master
    logic [31:0] d_addr_i;
    logic        d_valid_i;
    logic [31:0] d_data_write_i;
    logic [3:0]  d_wstrb_i;
    logic        d_ready_o;
    logic [31:0] d_data_read_o;

    // merged slave bus
    logic [31:0] m_addr_o;
    logic        m_valid_o;
    logic [31:0] m_data_write_o;
    logic [3:0]  m_wstrb_o;
    logic        m_ready_i;
    logic [31:0] m_data_read_i;

    // watchdog error pulse
    logic        bus_err_o;

    modport slave (
        input  i_addr_i, i_valid_i,
        output i_ready_o, i_data_read_o,
        input  d_addr_i, d_valid_i, d_data_write_i, d_wstrb_i,
        output d_ready_o, d_data_read_o,
        output m_addr_o, m_valid_o, m_data_write_o, m_wstrb_o,
        input  m_ready_i, m_data_read_i,
        output bus_err_o
    );

    modport master (
        output i_addr_i, i_valid_i,
        input  i_ready_o, i_data_read_o,
        output d_addr_i, d_valid_i, d_data_write_i, d_wstrb_i,
        input  d_ready_o, d_data_read_o,
        input  m_addr_o, m_valid_o, m_data_write_o, m_wstrb_o,
        output m_ready_i, m_data_read_i,
        input  bus_err_o
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Two-master (instruction/data) to one-slave round-robin arbiter with a transfer watchdog.
// Latency: request sampled in IDLE -> slave valid next cycle; slave ready -> master ready same cycle.
// Backpressure: grant held until slave ready, master abort or watchdog timeout; losing master waits.
//
// Ports:
//   clk_i           clock, rising edge
//   rst_i           synchronous active-high reset
//   bus (slave)     instruction master, data master, merged slave bus and bus_err_o
//
// Parameters:
//   TIMEOUT_CYCLES  slave-valid cycles allowed before a forced completion (0 = watchdog off)
//   TIMEOUT_DATA    read data returned to the master on a forced completion
module mem_bus_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter logic [31:0] TIMEOUT_DATA   = 32'hDEAD_BEEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    mem_bus_arbiter_if.slave  bus
);

    // Counter must be able to hold TIMEOUT_CYCLES itself; keep at least one bit
    // so the disabled-watchdog build still has a legal vector.
    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);
    localparam bit WATCHDOG_ON = (TIMEOUT_CYCLES != 0);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2
    } state_t;

    state_t           state;
    logic             last_d;     // 1: data master was granted most recently
    logic [CNT_W-1:0] wd_cnt;

    logic             gnt_i;
    logic             gnt_d;
    logic             gnt_valid;  // granted master still requesting
    logic             wd_hit;
    logic             timeout;
    logic             slv_valid;
    logic             slv_done;
    logic             xfer_end;

    // ------------------------------------------------------------------
    // Grant-phase qualifiers. All depend on registered state, so in IDLE
    // nothing from a master's valid reaches the slave bus.
    // ------------------------------------------------------------------
    always_comb begin
        gnt_i     = (state == GRANT_I);
        gnt_d     = (state == GRANT_D);
        gnt_valid = (gnt_i & bus.i_valid_i) | (gnt_d & bus.d_valid_i);
        wd_hit    = WATCHDOG_ON && (wd_cnt == TIMEOUT_VAL);
        // A master that has already dropped valid is an abort, not a timeout.
        timeout   = gnt_valid & wd_hit;
        slv_valid = gnt_valid & ~wd_hit;
        // Slave ready is only honoured while the request is actually presented,
        // which also makes a ready in the timeout cycle irrelevant.
        slv_done  = slv_valid & bus.m_ready_i;
        xfer_end  = slv_done | timeout | ~gnt_valid;
    end

    // ------------------------------------------------------------------
    // Slave-side request mux. The instruction master never writes, so its
    // grant forces write data and strobes to zero.
    // ------------------------------------------------------------------
    always_comb begin
        bus.m_valid_o      = slv_valid;
        bus.m_addr_o       = 32'd0;
        bus.m_data_write_o = 32'd0;
        bus.m_wstrb_o      = 4'd0;
        if (gnt_i) begin
            bus.m_addr_o = bus.i_addr_i;
        end else if (gnt_d) begin
            bus.m_addr_o       = bus.d_addr_i;
            bus.m_data_write_o = bus.d_data_write_i;
            bus.m_wstrb_o      = bus.d_wstrb_i;
        end
    end

    // ------------------------------------------------------------------
    // Master-side completion. Read data is only passed through in the
    // completing cycle; otherwise it is held at zero.
    // ------------------------------------------------------------------
    always_comb begin
        bus.i_ready_o     = 1'b0;
        bus.i_data_read_o = 32'd0;
        bus.d_ready_o     = 1'b0;
        bus.d_data_read_o = 32'd0;
        bus.bus_err_o     = timeout;
        if (gnt_i) begin
            if (timeout) begin
                bus.i_ready_o     = 1'b1;
                bus.i_data_read_o = TIMEOUT_DATA;
            end else if (slv_done) begin
                bus.i_ready_o     = 1'b1;
                bus.i_data_read_o = bus.m_data_read_i;
            end
        end else if (gnt_d) begin
            if (timeout) begin
                bus.d_ready_o     = 1'b1;
                bus.d_data_read_o = TIMEOUT_DATA;
            end else if (slv_done) begin
                bus.d_ready_o     = 1'b1;
                bus.d_data_read_o = bus.m_data_read_i;
            end
        end
    end

    // ------------------------------------------------------------------
    // Arbitration FSM, round-robin pointer and watchdog counter.
    // Every grant returns to IDLE, which gives the mandatory idle cycle
    // between transfers and lets the pointer alternate under contention.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state  <= IDLE;
            last_d <= 1'b0;     // instruction counts as last, so data wins the first tie
            wd_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.i_valid_i && (!bus.d_valid_i || last_d)) begin
                        state  <= GRANT_I;
                        last_d <= 1'b0;
                        wd_cnt <= '0;
                    end else if (bus.d_valid_i) begin
                        state  <= GRANT_D;
                        last_d <= 1'b1;
                        wd_cnt <= '0;
                    end
                end
                GRANT_I, GRANT_D: begin
                    if (xfer_end) begin
                        state <= IDLE;
                    end else if (!bus.m_ready_i) begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter (TIMEOUT_CYCLES = 4).
// Per-cycle vectors: inputs applied just after a rising edge, outputs compared mid-cycle.
// Completions are also matched against a scoreboard of expected read responses.
module tb_mem_bus_arbiter;

    localparam logic [31:0] I_ADDR = 32'h0000_0100;
    localparam logic [31:0] D_ADDR = 32'h0000_0200;
    localparam logic [31:0] WDATA  = 32'hCAFE_F00D;
    localparam logic [3:0]  WSTRB  = 4'hF;
    localparam logic [31:0] NOISE  = 32'h5555_AAAA;
    localparam logic [31:0] TDATA  = 32'hDEAD_BEEF;

    logic clk;
    logic rst;

    mem_bus_arbiter_if bus ();

    mem_bus_arbiter #(
        .TIMEOUT_CYCLES (4),
        .TIMEOUT_DATA   (TDATA)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        iv;
        logic        dv;
        logic        mr;
        logic [31:0] mdr;
        logic        e_mv;
        logic        e_ir;
        logic        e_dr;
        logic        e_err;
        logic [31:0] e_addr;
        logic [3:0]  e_wstrb;
        logic [31:0] e_rd;
    } vec_t;

    typedef struct {
        logic        is_d;
        logic [31:0] data;
        logic        err;
    } sb_t;

    vec_t tbl[$];
    sb_t  sb[$];
    int   n_chk = 0;
    int   n_err = 0;
    int   cyc   = 0;
    bit   in_cont = 0;
    int   cont_i = 0;
    int   cont_d = 0;

    function automatic vec_t mk(logic r, logic iv, logic dv, logic mr, logic [31:0] mdr,
                                logic emv, logic eir, logic edr, logic eerr,
                                logic [31:0] eaddr, logic [3:0] ewstrb, logic [31:0] erd);
        vec_t v;
        v.rst = r;     v.iv = iv;     v.dv = dv;     v.mr = mr;     v.mdr = mdr;
        v.e_mv = emv;  v.e_ir = eir;  v.e_dr = edr;  v.e_err = eerr;
        v.e_addr = eaddr; v.e_wstrb = ewstrb; v.e_rd = erd;
        return v;
    endfunction

    // Arbiter in IDLE: slave bus and both masters see nothing.
    function automatic vec_t idle(logic iv, logic dv);
        return mk(1'b0, iv, dv, 1'b0, NOISE, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
    endfunction

    // Granted cycle with the granted master requesting; mr=1 completes it.
    function automatic vec_t gnt(logic is_d, logic iv, logic dv, logic mr, logic [31:0] mdr);
        return mk(1'b0, iv, dv, mr, mdr, 1'b1, !is_d && mr, is_d && mr, 1'b0,
                  is_d ? D_ADDR : I_ADDR, is_d ? WSTRB : 4'd0, mr ? mdr : 32'd0);
    endfunction

    // Watchdog timeout cycle: slave valid withdrawn, forced completion with error.
    function automatic vec_t tmo(logic is_d, logic iv, logic dv, logic mr, logic [31:0] mdr);
        return mk(1'b0, iv, dv, mr, mdr, 1'b0, !is_d, is_d, 1'b1,
                  is_d ? D_ADDR : I_ADDR, is_d ? WSTRB : 4'd0, TDATA);
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // One clock cycle: drive, record expected response, compare mid-cycle.
    task automatic cycle(vec_t v);
        string   t;
        sb_t     s;
        logic [31:0] act_rd;
        rst              = v.rst;
        bus.i_valid_i    = v.iv;
        bus.d_valid_i    = v.dv;
        bus.m_ready_i    = v.mr;
        bus.m_data_read_i = v.mdr;
        if (v.e_ir || v.e_dr) begin
            s.is_d = v.e_dr;
            s.data = v.e_rd;
            s.err  = v.e_err;
            sb.push_back(s);
        end
        @(negedge clk);
        t = $sformatf("c%0d", cyc);
        chk({t, " m_valid"},  {31'd0, bus.m_valid_o}, {31'd0, v.e_mv});
        chk({t, " i_ready"},  {31'd0, bus.i_ready_o}, {31'd0, v.e_ir});
        chk({t, " d_ready"},  {31'd0, bus.d_ready_o}, {31'd0, v.e_dr});
        chk({t, " bus_err"},  {31'd0, bus.bus_err_o}, {31'd0, v.e_err});
        chk({t, " m_addr"},   bus.m_addr_o, v.e_addr);
        chk({t, " m_wstrb"},  {28'd0, bus.m_wstrb_o}, {28'd0, v.e_wstrb});
        chk({t, " m_wdata"},  bus.m_data_write_o, (v.e_addr == D_ADDR) ? WDATA : 32'd0);
        chk({t, " i_rdata"},  bus.i_data_read_o, v.e_ir ? v.e_rd : 32'd0);
        chk({t, " d_rdata"},  bus.d_data_read_o, v.e_dr ? v.e_rd : 32'd0);
        // Scoreboard side: every ready the DUT raises must match a queued response.
        if (bus.i_ready_o || bus.d_ready_o) begin
            if (in_cont) begin
                if (bus.i_ready_o) cont_i++;
                if (bus.d_ready_o) cont_d++;
            end
            if (sb.size() == 0) begin
                n_chk++;
                n_err++;
                $display("FAIL %s sb_unexpected_ready: got i=%0b d=%0b, expected none",
                         t, bus.i_ready_o, bus.d_ready_o);
            end else begin
                s = sb.pop_front();
                act_rd = bus.d_ready_o ? bus.d_data_read_o : bus.i_data_read_o;
                chk({t, " sb_master"}, {31'd0, bus.d_ready_o}, {31'd0, s.is_d});
                chk({t, " sb_data"},   act_rd, s.data);
                chk({t, " sb_err"},    {31'd0, bus.bus_err_o}, {31'd0, s.err});
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        vec_t v;

        rst                = 1'b1;
        bus.i_addr_i       = I_ADDR;
        bus.i_valid_i      = 1'b0;
        bus.d_addr_i       = D_ADDR;
        bus.d_valid_i      = 1'b0;
        bus.d_data_write_i = WDATA;
        bus.d_wstrb_i      = WSTRB;
        bus.m_ready_i      = 1'b0;
        bus.m_data_read_i  = 32'd0;

        // ---- vector table ------------------------------------------------
        // Single instruction read, zero wait.
        tbl.push_back(idle(1, 0));
        tbl.push_back(gnt(0, 1, 0, 1, 32'h1234_5678));
        tbl.push_back(idle(0, 0));
        // Tie with last=I: data first, one idle cycle, then instruction.
        tbl.push_back(idle(1, 1));
        tbl.push_back(gnt(1, 1, 1, 1, 32'hAAAA_0001));
        tbl.push_back(idle(1, 0));
        tbl.push_back(gnt(0, 1, 0, 1, 32'hBBBB_0002));
        tbl.push_back(idle(0, 0));
        // Sustained contention: 8 transfers alternating D,I,...
        for (int k = 0; k < 8; k++) begin
            tbl.push_back(idle(1, 1));
            tbl.push_back(gnt((k % 2) == 0, 1, 1, 1, 32'h3000_0000 + 32'(k)));
        end
        tbl.push_back(idle(0, 0));
        // Wait states: slave ready on its 3rd valid cycle, no error.
        tbl.push_back(idle(0, 1));
        tbl.push_back(gnt(1, 0, 1, 0, NOISE));
        tbl.push_back(gnt(1, 0, 1, 0, NOISE));
        tbl.push_back(gnt(1, 0, 1, 1, 32'hCCCC_0003));
        tbl.push_back(idle(0, 0));
        // Timeout: 4 valid cycles, then forced completion; late slave ready ignored.
        tbl.push_back(idle(0, 1));
        for (int k = 0; k < 4; k++) tbl.push_back(gnt(1, 0, 1, 0, NOISE));
        tbl.push_back(tmo(1, 0, 1, 1, 32'h1111_1111));
        tbl.push_back(idle(0, 0));
        // Abort: instruction master drops valid mid-grant.
        tbl.push_back(idle(1, 0));
        tbl.push_back(gnt(0, 1, 0, 0, NOISE));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, NOISE, 1'b0, 1'b0, 1'b0, 1'b0,
                         I_ADDR, 4'd0, 32'd0));
        tbl.push_back(idle(1, 0));
        tbl.push_back(gnt(0, 1, 0, 1, 32'hDDDD_0004));
        tbl.push_back(idle(0, 0));

        // ---- reset state -------------------------------------------------
        repeat (2) @(posedge clk);
        #1;
        cycle(mk(1'b1, 1'b0, 1'b0, 1'b0, NOISE, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0));

        // ---- table run ---------------------------------------------------
        for (int n = 0; n < tbl.size(); n++) begin
            in_cont = (n >= 8) && (n < 24);
            cycle(tbl[n]);
        end
        in_cont = 0;
        chk("cont_i_readies", 32'(cont_i), 32'd4);
        chk("cont_d_readies", 32'(cont_d), 32'd4);

        // ---- reset mid-transfer ------------------------------------------
        cycle(idle(0, 1));
        cycle(gnt(1, 0, 1, 0, NOISE));
        cycle(gnt(1, 0, 1, 0, NOISE));
        v = gnt(1, 0, 1, 0, NOISE);
        v.rst = 1'b1;
        cycle(v);                                   // reset takes effect at the closing edge
        cycle(idle(1, 1));                          // back in IDLE, all outputs zero
        cycle(gnt(1, 1, 1, 1, 32'hEEEE_0005));      // pointer reset: data wins the tie
        cycle(idle(1, 0));
        cycle(gnt(0, 1, 0, 1, 32'hFFFF_0006));
        cycle(idle(0, 0));

        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
